// File: rtl/glip_seq_checker_if.sv
// GLIP input FIFO read handshake.
// master drives data/valid, slave returns ready.
interface glip_seq_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/glip_seq_checker.sv
// Incrementing-sequence checker for the GLIP loopback path.
// Locks on the first word, then flags every out-of-sequence word.
module glip_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int THROTTLE = 0,
  parameter int MAX_MISS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  glip_seq_checker_if.slave   in_if,
  output logic                locked,
  output logic                error,
  output logic                sticky_error,
  output logic [15:0]         err_count,
  output logic [31:0]         rx_count
);

  localparam int TW = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
  localparam logic [3:0] MISS_LAST = 4'(MAX_MISS - 1);
  localparam logic [TW-1:0] THR_LAST = TW'(THROTTLE);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CHECK
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] expected_d;
  logic [3:0]       miss_q;
  logic [3:0]       miss_d;
  logic [TW-1:0]    thr_q;
  logic             xfer;
  logic             err_d;

  assign in_if.in_ready = (state_q != IDLE) && (thr_q == '0);
  assign xfer = in_if.in_valid && in_if.in_ready;

  // State, expected word and miss counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      expected_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      miss_q     <= miss_d;
    end
  end

  // Next state, resync and miss tracking; leaving enable wins the state
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        if (xfer) begin
          expected_d = in_if.in_data + WIDTH'(1);
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (in_if.in_data == expected_q) begin
            expected_d = expected_q + WIDTH'(1);
            miss_d     = '0;
          end else begin
            err_d      = 1'b1;
            expected_d = in_if.in_data + WIDTH'(1);
            if (miss_q == MISS_LAST) begin
              miss_d  = '0;
              state_d = SYNC;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !enable) state_d = IDLE;
  end

  // Throttle phase: parked at 0 while idle so ready comes up at once
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      thr_q <= '0;
    end else if (thr_q == THR_LAST) begin
      thr_q <= '0;
    end else begin
      thr_q <= thr_q + TW'(1);
    end
  end

  // Status outputs and counters; clear beats increments, not the pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      locked       <= 1'b0;
      error        <= 1'b0;
      sticky_error <= 1'b0;
      err_count    <= '0;
      rx_count     <= '0;
    end else begin
      locked <= (state_d == CHECK);
      error  <= err_d;
      if (clear) begin
        sticky_error <= 1'b0;
        err_count    <= '0;
        rx_count     <= '0;
      end else begin
        if (xfer) rx_count <= rx_count + 32'd1;
        if (err_d) sticky_error <= 1'b1;
        if (err_d && err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
